booth_seq_mult: RTL
===================

# booth_seq_mult

Iterative radix-4 Booth multiplier with a start/done handshake, a parametrised operand width, and a run-time signed/unsigned mode. It replaces the single-pass combinational Booth array in the ALU multiply path. It produces the 2×WIDTH product as HI/LO halves for the HI/LO register pair. Each operation takes a fixed WIDTH/2+1 iteration cycles, which keeps the multiplier off the critical path.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- clock  input  1  rising-edge clock for all state
- clear_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on a rising edge only in IDLE or DONE
- signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned; captured with start
- multiplicand  input  WIDTH  M; captured on the accepting edge
- multiplier  input  WIDTH  Q; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE
- outHI  output  WIDTH  product[2·WIDTH-1:WIDTH]
- outLO  output  WIDTH  product[WIDTH-1:0]

## Operation
- States:
  - IDLE: start=1 → RUN.
  - RUN: iteration counter reaches last → DONE.
  - DONE: start=1 → RUN (back-to-back); otherwise → IDLE.
- Capture on the accepting edge:
  - Extend M and Q to WIDTH+2 bits: sign-extend if signed_mode=1, zero-extend if 0.
  - Clear the accumulator to 0 and the Booth guard bit q_-1 to 0.
  - Load the iteration counter with 0.
- Each RUN cycle:
  - Recode the triplet {Q[1], Q[0], q_-1} to a digit d ∈ {0, +1, +1, +2, −2, −1, −1, 0} for triplet values 000…111.
  - Add d·M to the upper (WIDTH+2)-bit accumulator; width is WIDTH+4 internally so ±2M never overflows.
  - Shift {acc, Q, q_-1} arithmetically right by 2, preserving the acc sign.
- Iterations: exactly N = (WIDTH+2)/2 = WIDTH/2+1. In signed mode the final digit is always 0; the count is the same in both modes.
- Result: after the final iteration, the low 2·WIDTH bits of {acc, Q} form the exact product, modulo nothing. On the RUN→DONE edge they are registered into outHI/outLO.
- outHI/outLO hold their value until the next DONE edge. They do not change during a subsequent RUN.
- start while busy=1 is ignored: no capture, no effect on the current operation.
- Operands and signed_mode changing during RUN have no effect.
- Corner values must be exact:
  - Signed: −2^(WIDTH−1) × −2^(WIDTH−1) = 2^(2·WIDTH−2).
  - Unsigned: (2^WIDTH−1)².

## Timing
- Reset (clear_n=0, asynchronous):
  - State → IDLE; busy=0, done=0, outHI=0, outLO=0.
  - Accumulator, Q and counter → 0.
  - Takes effect immediately, including mid-RUN; the operation in progress is discarded.
- Release is synchronous to the clock. The first edge with clear_n=1 may accept start.
- Latency: start accepted at edge E0 →
  - busy=1 from E0 through E0+N.
  - At E0+N: state → DONE, outHI/outLO valid, done=1 for exactly one cycle.
- Throughput: one product per N+1 cycles. With start held high in DONE, the next operation is accepted at E0+N+1 and busy stays 0 for that one DONE cycle only.
- done and busy are never high together.

## Test plan
- Signed small (WIDTH=32): signed_mode=1, M=0xFFFFFFF9 (−7), Q=3, start pulse → after 17 cycles outHI=0xFFFFFFFF, outLO=0xFFFFFFEB, done high for 1 cycle, busy high for exactly 17 cycles.
- Unsigned max: signed_mode=0, M=Q=0xFFFFFFFF → outHI=0xFFFFFFFE, outLO=0x00000001. Same operands with signed_mode=1 → outHI=0x00000000, outLO=0x00000001.
- Most-negative: signed_mode=1, M=Q=0x80000000 → outHI=0x40000000, outLO=0x00000000. Also M=0x80000000, Q=1 → outHI=0xFFFFFFFF, outLO=0x80000000.
- Handshake:
  - Start 6×7, then pulse start with 2×2 at cycle 5 of RUN → result 42 (outLO=0x2A) and no extra done.
  - Hold start high through DONE with new operands 5×5 → second done exactly 18 cycles after the first, outLO=0x19.
- Reset mid-operation: assert clear_n=0 for half a cycle at RUN cycle 8 → busy, done, outHI and outLO go to 0 immediately, state IDLE, no done pulse follows. The next start completes normally.
- Parameter sweep WIDTH=8: 2000 random operands per mode against a reference product → exact match; latency is 5 cycles.

Source files
------------

// File: rtl/booth_seq_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// booth_seq_mult
//
// Iterative radix-4 Booth multiplier. An operation is accepted with a start
// request in IDLE or DONE, runs for exactly WIDTH/2+1 iteration cycles and
// presents the full 2*WIDTH-bit product as two WIDTH-bit halves. Both
// operands are read as two's complement (signed_mode=1) or as unsigned
// (signed_mode=0).
//
// Parameters
//   WIDTH         operand width; must be even and >= 4
//
// Ports
//   clock         rising-edge clock for all state
//   clear_n       asynchronous active-low reset
//   start         operation request, honoured only in IDLE or DONE
//   signed_mode   operand interpretation, captured together with start
//   multiplicand  M, captured on the accepting edge
//   multiplier    Q, captured on the accepting edge
//   busy          high while iterating
//   done          one-cycle pulse when the product has been registered
//   outHI         product[2*WIDTH-1:WIDTH], held until the next completion
//   outLO         product[WIDTH-1:0], held until the next completion
// -----------------------------------------------------------------------------
module booth_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] outHI,
   output logic [WIDTH-1:0] outLO
);

   // Operands are extended by two bits so unsigned values become non-negative
   // signed numbers; the Booth recoding then only has to handle the signed case.
   localparam int EW = WIDTH + 2;
   // Two further guard bits keep acc +/- 2M from overflowing.
   localparam int AW = WIDTH + 4;
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic            load;
   logic            step;
   logic            last_iter;

   logic [EW-1:0]   m_reg;
   logic [EW-1:0]   q_reg;
   logic            qm1_reg;
   logic [AW-1:0]   acc_reg;
   logic [CW-1:0]   cnt_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;

   logic [EW-1:0]   m_in_ext;
   logic [EW-1:0]   q_in_ext;
   logic [AW-1:0]   m_acc;
   logic [AW-1:0]   addend;
   logic [AW-1:0]   sum;
   logic [AW-1:0]   acc_step;
   logic [EW-1:0]   q_step;
   logic [2*WIDTH-1:0] prod;

   assign last_iter = (cnt_reg == LAST);

   // -------------------------------------------------------------------------
   // Control: next state and decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: one radix-4 Booth step
   // -------------------------------------------------------------------------
   assign m_in_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                 : {2'b00, multiplicand};
   assign q_in_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                 : {2'b00, multiplier};

   assign m_acc = {{2{m_reg[EW-1]}}, m_reg};

   always_comb begin
      addend = '0;
      case ({q_reg[1:0], qm1_reg})
         3'b001, 3'b010: addend = m_acc;
         3'b011:         addend = m_acc << 1;
         3'b100:         addend = -(m_acc << 1);
         3'b101, 3'b110: addend = -m_acc;
         default:        addend = '0;
      endcase
   end

   assign sum = acc_reg + addend;

   // {acc, Q, q_-1} shifted right by two with the accumulator sign replicated.
   assign acc_step = {{2{sum[AW-1]}}, sum[AW-1:2]};
   assign q_step   = {sum[1:0], q_reg[EW-1:2]};

   // After the last step Q holds the low EW product bits and the accumulator
   // supplies the remaining upper bits.
   assign prod = {acc_step[WIDTH-3:0], q_step};

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_reg <= IDLE;
         m_reg     <= '0;
         q_reg     <= '0;
         qm1_reg   <= 1'b0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            m_reg   <= m_in_ext;
            q_reg   <= q_in_ext;
            qm1_reg <= 1'b0;
            acc_reg <= '0;
            cnt_reg <= '0;
         end else if (step) begin
            acc_reg <= acc_step;
            q_reg   <= q_step;
            qm1_reg <= q_reg[1];
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter) begin
               hi_reg <= prod[2*WIDTH-1:WIDTH];
               lo_reg <= prod[WIDTH-1:0];
            end
         end
      end
   end

   assign outHI = hi_reg;
   assign outLO = lo_reg;

endmodule
